// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide, STEP bits per cycle.
// Define MULDIV_EARLY_OUT_EN to finish trivial cases (x/0, overflow, zero multiply) straight from IDLE.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            busy
);
  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op_q;
  logic sign_a, sign_b, in_sa, in_sb, last, start, early;
  logic [CW-1:0] count;
  logic [XLEN-1:0] a_mag, b_mag, in_a, in_b, quo, quo_nx, rem, rem_nx, q_fix, r_fix, res_full;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [XLEN:0] sum, r, diff;
  assign in_sa = (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110) && rdata1[XLEN-1];
  assign in_sb = (op == 3'b001 || op == 3'b100 || op == 3'b110) && rdata2[XLEN-1];
  assign in_a  = in_sa ? -rdata1 : rdata1;
  assign in_b  = in_sb ? -rdata2 : rdata2;
  assign start = state == IDLE && enable && !kill;
  assign last  = count == CW'(N - 1);
  assign ready = state == DONE && !kill && reset;
  assign busy  = state == BUSY;
`ifdef MULDIV_EARLY_OUT_EN
  logic div0, ovf, mzero;
  logic [XLEN-1:0] early_res;
  assign div0  = op[2] && rdata2 == '0;
  assign ovf   = (op == 3'b100 || op == 3'b110) && rdata1 == {1'b1, {(XLEN-1){1'b0}}} && rdata2 == '1;
  assign mzero = !op[2] && (rdata1 == '0 || rdata2 == '0);
  assign early = div0 || ovf || mzero;
  assign early_res = mzero ? '0 : div0 ? (op[1] ? rdata1 : '1) : (op[1] ? '0 : rdata1);
`else
  assign early = 1'b0;
`endif
  // Shift-add multiply in acc; restoring divide shifts dividend out of quo into rem.
  always_comb begin
    acc_nx = acc;
    quo_nx = quo;
    rem_nx = rem;
    sum = '0;
    r = '0;
    diff = '0;
    for (int i = 0; i < STEP; i++) begin
      sum = {1'b0, acc_nx[2*XLEN-1:XLEN]} + (acc_nx[0] ? {1'b0, a_mag} : '0);
      acc_nx = {sum, acc_nx[XLEN-1:1]};
      r = {rem_nx, quo_nx[XLEN-1]};
      diff = r - {1'b0, b_mag};
      rem_nx = diff[XLEN] ? r[XLEN-1:0] : diff[XLEN-1:0];
      quo_nx = {quo_nx[XLEN-2:0], ~diff[XLEN]};
    end
  end
  always_comb begin
    prod = (sign_a ^ sign_b) ? -acc_nx : acc_nx;
    q_fix = (sign_a ^ sign_b && b_mag != '0) ? -quo_nx : quo_nx;
    r_fix = sign_a ? -rem_nx : rem_nx;
    res_full = op_q == 3'b000 ? prod[XLEN-1:0] : !op_q[2] ? prod[2*XLEN-1:XLEN] : !op_q[1] ? q_fix : r_fix;
  end
  always_comb begin
    state_nx = kill ? IDLE :
               state == IDLE ? (enable ? (early ? DONE : BUSY) : IDLE) :
               state == BUSY ? (last ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      op_q <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_mag <= '0;
      b_mag <= '0;
      acc <= '0;
      quo <= '0;
      rem <= '0;
      count <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        op_q <= op;
        sign_a <= in_sa;
        sign_b <= in_sb;
        a_mag <= in_a;
        b_mag <= in_b;
        acc <= {{XLEN{1'b0}}, in_b};
        quo <= in_a;
        rem <= '0;
        count <= '0;
`ifdef MULDIV_EARLY_OUT_EN
        if (early) result <= early_res;
`endif
      end else if (state == BUSY && !kill) begin
        acc <= acc_nx;
        quo <= quo_nx;
        rem <= rem_nx;
        count <= count + 1'b1;
        if (last) result <= res_full;
      end
    end
  end
endmodule
